// File: rtl/dfd_arb_pkg.sv
// Shared types and limits for the dfd_* function-call arbiter.
package dfd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALL  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  localparam int MAX_CALLERS = 8;
  // Grant indices are always sized for the largest supported caller count.
  localparam int GRANT_W = $clog2(MAX_CALLERS);

endpackage

// File: rtl/dfd_call_arbiter_rr_priority_pick.sv
// Round-robin pick: rotate requests so last_grant+1 sits at bit 0,
// fixed-priority encode, then rotate the winning position back.
module rr_priority_pick
  import dfd_arb_pkg::*;
#(
  parameter int NUM_CALLERS = 4
) (
  input  logic [NUM_CALLERS-1:0] req,
  input  logic [GRANT_W-1:0]     last_grant,
  output logic [GRANT_W-1:0]     grant_idx,
  output logic                   any_req
);

  logic [GRANT_W-1:0]     start_idx;
  logic [NUM_CALLERS-1:0] rot_req;
  logic [GRANT_W-1:0]     pos;
  logic [GRANT_W:0]       sum;

  always_comb begin
    start_idx = (last_grant >= GRANT_W'(NUM_CALLERS - 1)) ? '0 : last_grant + GRANT_W'(1);
    rot_req   = (req >> start_idx) | (req << (NUM_CALLERS - int'(start_idx)));

    pos = '0;
    for (int i = NUM_CALLERS - 1; i >= 0; i--) begin
      if (rot_req[i]) pos = GRANT_W'(i);
    end

    sum = {1'b0, start_idx} + {1'b0, pos};
    if (sum >= (GRANT_W + 1)'(NUM_CALLERS)) grant_idx = GRANT_W'(sum - (GRANT_W + 1)'(NUM_CALLERS));
    else                                    grant_idx = GRANT_W'(sum);

    any_req = |req;
  end

endmodule

// File: rtl/dfd_call_arbiter.sv
// Shares one dfd_* function core between several requesters: round-robin
// grant, argument latch, one-cycle result ack, optional call watchdog.
module dfd_call_arbiter
  import dfd_arb_pkg::*;
#(
  parameter int NUM_CALLERS    = 4,
  parameter int ARGS_WIDTH     = 16,
  parameter int RESULT_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                              CLOCK_50,
  input  logic                              reset,
  input  logic [NUM_CALLERS-1:0]            caller_req,
  input  logic [NUM_CALLERS*ARGS_WIDTH-1:0] caller_args,
  output logic [NUM_CALLERS-1:0]            caller_ack,
  output logic [RESULT_WIDTH-1:0]           caller_result,
  output logic                              caller_error,
  output logic                              busy,
  output logic                              fn_ready,
  output logic [ARGS_WIDTH-1:0]             fn_args,
  input  logic                              fn_done,
  input  logic [RESULT_WIDTH-1:0]           fn_result
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  arb_state_t               state_reg;
  logic [GRANT_W-1:0]       grant_idx_reg;
  logic [GRANT_W-1:0]       last_grant_reg;
  logic [CNT_W-1:0]         cnt_reg;
  logic [NUM_CALLERS-1:0]   ack_reg;
  logic [RESULT_WIDTH-1:0]  result_reg;
  logic                     error_reg;
  logic                     busy_reg;
  logic                     fn_ready_reg;
  logic [ARGS_WIDTH-1:0]    fn_args_reg;

  logic [GRANT_W-1:0]       pick_idx;
  logic                     any_req;
  logic                     timeout_hit;

  // Padded to MAX_CALLERS so a GRANT_W-bit index always lands in range.
  logic [ARGS_WIDTH-1:0] args_arr [MAX_CALLERS];

  genvar gi;
  generate
    for (gi = 0; gi < MAX_CALLERS; gi++) begin : g_args
      if (gi < NUM_CALLERS) begin : g_used
        assign args_arr[gi] = caller_args[gi*ARGS_WIDTH +: ARGS_WIDTH];
      end else begin : g_pad
        assign args_arr[gi] = '0;
      end
    end
  endgenerate

  rr_priority_pick #(
    .NUM_CALLERS(NUM_CALLERS)
  ) u_pick (
    .req        (caller_req),
    .last_grant (last_grant_reg),
    .grant_idx  (pick_idx),
    .any_req    (any_req)
  );

  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_reg == CNT_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      grant_idx_reg  <= '0;
      last_grant_reg <= GRANT_W'(NUM_CALLERS - 1);
      cnt_reg        <= '0;
      ack_reg        <= '0;
      result_reg     <= '0;
      error_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      fn_ready_reg   <= 1'b0;
      fn_args_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (any_req) begin
            fn_args_reg   <= args_arr[pick_idx];
            grant_idx_reg <= pick_idx;
            fn_ready_reg  <= 1'b1;
            cnt_reg       <= '0;
            busy_reg      <= 1'b1;
            state_reg     <= ST_CALL;
          end
        end
        ST_CALL: begin
          // A real completion wins over a watchdog expiry on the same edge.
          if (fn_done) begin
            result_reg     <= fn_result;
            ack_reg        <= NUM_CALLERS'(1) << grant_idx_reg;
            error_reg      <= 1'b0;
            fn_ready_reg   <= 1'b0;
            last_grant_reg <= grant_idx_reg;
            state_reg      <= ST_DRAIN;
          end else if (timeout_hit) begin
            result_reg     <= '0;
            ack_reg        <= NUM_CALLERS'(1) << grant_idx_reg;
            error_reg      <= 1'b1;
            fn_ready_reg   <= 1'b0;
            last_grant_reg <= grant_idx_reg;
            state_reg      <= ST_DRAIN;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          ack_reg   <= '0;
          error_reg <= 1'b0;
          if (!fn_done) begin
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          busy_reg     <= 1'b0;
          fn_ready_reg <= 1'b0;
          ack_reg      <= '0;
          error_reg    <= 1'b0;
          state_reg    <= ST_IDLE;
        end
      endcase
    end
  end

  assign caller_ack    = ack_reg;
  assign caller_result = result_reg;
  assign caller_error  = error_reg;
  assign busy          = busy_reg;
  assign fn_ready      = fn_ready_reg;
  assign fn_args       = fn_args_reg;

endmodule
